// File: rtl/axis_tg_pkg.sv
// Shared types and helpers for the AXI-Stream traffic checker.
//
// Contents:
//   state_t  - run-control states IDLE / RUNNING / DRAIN / DONE
//   SEQ_LSB  - bit offset of the sequence number inside tdata
//   ts_lsb() - bit offset of the send timestamp (upper half of tdata)
//   sat_sub()- modular timestamp difference clamped to an output width
package axis_tg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Sequence number sits at the bottom of the beat; timestamp fills the upper half.
    localparam int SEQ_LSB  = 0;
    localparam int MAX_TS_W = 256;

    function automatic int ts_lsb(input int tdata_w);
        return tdata_w / 2;
    endfunction

    // (a - b) modulo 2**ts_w, so a wrapped time base still yields the true
    // distance. Any result that does not fit in w bits becomes all-ones of w.
    function automatic logic [MAX_TS_W-1:0] sat_sub(
        input logic [MAX_TS_W-1:0] a,
        input logic [MAX_TS_W-1:0] b,
        input int                  ts_w,
        input int                  w
    );
        logic [MAX_TS_W-1:0] ones;
        logic [MAX_TS_W-1:0] diff;
        ones = '1;
        diff = (a - b) & (ones >> (MAX_TS_W - ts_w));
        if ((diff >> w) != '0) begin
            return ones >> (MAX_TS_W - w);
        end
        return diff;
    endfunction

endpackage

// File: rtl/axis_tc_lat_stats.sv
// Latency statistics accumulator.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - restart statistics (sum 0, min all-ones, max 0)
//   sample_vld  - sample qualifies this cycle
//   sample      - latency sample, LAT_WIDTH bits
//   lat_sum     - saturating sum of samples
//   lat_min     - smallest sample seen
//   lat_max     - largest sample seen
module axis_tc_lat_stats #(
    parameter int LAT_WIDTH = 32,
    parameter int SUM_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 sample_vld,
    input  logic [LAT_WIDTH-1:0] sample,
    output logic [SUM_WIDTH-1:0] lat_sum,
    output logic [LAT_WIDTH-1:0] lat_min,
    output logic [LAT_WIDTH-1:0] lat_max
);

    // Sum sticks at all-ones once it overflows.
    function automatic logic [SUM_WIDTH-1:0] sat_add(
        input logic [SUM_WIDTH-1:0] acc,
        input logic [LAT_WIDTH-1:0] s
    );
        logic [SUM_WIDTH:0] t;
        t = {1'b0, acc} + {{(SUM_WIDTH + 1 - LAT_WIDTH){1'b0}}, s};
        return t[SUM_WIDTH] ? '1 : t[SUM_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_sum <= '0;
            lat_min <= '1;
            lat_max <= '0;
        end else if (clear) begin
            lat_sum <= '0;
            lat_min <= '1;
            lat_max <= '0;
        end else if (sample_vld) begin
            lat_sum <= sat_add(lat_sum, sample);
            if (sample < lat_min) lat_min <= sample;
            if (sample > lat_max) lat_max <= sample;
        end
    end

endmodule

// File: rtl/axis_tc.sv
// Uniform-traffic sink/checker for one NoC egress port.
//
// Accepts single-beat packets, checks destination/tlast format and the
// per-source sequence numbers, counts good packets per source and keeps
// latency sum/min/max. Runs are gated by start/done like the generators.
//
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   start              - begin a run (honoured in IDLE/DONE only)
//   num_packets        - beats to accept before the run ends
//   ticks              - shared free-running time base
//   done               - high in IDLE and DONE
//   recv_packets       - good packets per source id
//   seq_err_count      - sequence mismatches
//   fmt_err_count      - beats with wrong tdest or tlast low
//   lat_sum/min/max    - latency statistics over good packets
//   axis_in_*          - AXI-Stream slave
module axis_tc
    import axis_tg_pkg::*;
#(
    parameter int TDATA_WIDTH = 512,
    parameter int TDEST_WIDTH = 2,
    parameter int TID_WIDTH   = 2,
    parameter int COUNT_WIDTH = 32,
    parameter int DEST_ID     = 0,
    parameter int LAT_WIDTH   = 32,
    parameter int SUM_WIDTH   = 64
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [COUNT_WIDTH-1:0]                      num_packets,
    input  logic [TDATA_WIDTH/2-1:0]                    ticks,
    output logic                                        done,
    output logic [2**TID_WIDTH-1:0][COUNT_WIDTH-1:0]    recv_packets,
    output logic [COUNT_WIDTH-1:0]                      seq_err_count,
    output logic [COUNT_WIDTH-1:0]                      fmt_err_count,
    output logic [SUM_WIDTH-1:0]                        lat_sum,
    output logic [LAT_WIDTH-1:0]                        lat_min,
    output logic [LAT_WIDTH-1:0]                        lat_max,
    input  logic                                        axis_in_tvalid,
    output logic                                        axis_in_tready,
    input  logic [TDATA_WIDTH-1:0]                      axis_in_tdata,
    input  logic                                        axis_in_tlast,
    input  logic [TID_WIDTH-1:0]                        axis_in_tid,
    input  logic [TDEST_WIDTH-1:0]                      axis_in_tdest
);

    localparam int NUM_SRC = 2**TID_WIDTH;
    localparam int TS_W    = TDATA_WIDTH / 2;
    localparam int TS_LSB  = ts_lsb(TDATA_WIDTH);
    localparam logic [TDEST_WIDTH-1:0] DEST = TDEST_WIDTH'(DEST_ID);

    state_t                                 state_q, state_d;
    logic [COUNT_WIDTH-1:0]                 total_recv_q;
    logic [NUM_SRC-1:0][COUNT_WIDTH-1:0]    exp_seq_q;
    logic                                   hs;
    logic                                   clear;

    logic                                   vld_p1;
    logic [TID_WIDTH-1:0]                   tid_p1;
    logic [COUNT_WIDTH-1:0]                 seq_p1;
    logic [TS_W-1:0]                        tx_p1;
    logic [TS_W-1:0]                        acc_p1;
    logic [TDEST_WIDTH-1:0]                 tdest_p1;
    logic                                   tlast_p1;

    logic                                   fmt_ok;
    logic                                   good;
    logic                                   seq_bad;
    logic [MAX_TS_W-1:0]                    tx_ext;
    logic [MAX_TS_W-1:0]                    acc_ext;
    logic [MAX_TS_W-1:0]                    lat_wide;
    logic [LAT_WIDTH-1:0]                   lat_sample;
    logic                                   unused_bits;

    // Run control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        done           = 1'b0;
        axis_in_tready = 1'b0;
        clear          = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = RUNNING;
                    clear   = 1'b1;
                end
            end
            RUNNING: begin
                // tready comes straight from the counter so the final beat
                // closes the window on the very next cycle.
                axis_in_tready = (total_recv_q < num_packets);
                if (total_recv_q >= num_packets) state_d = DRAIN;
            end
            DRAIN: begin
                if (!vld_p1) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hs = axis_in_tvalid && axis_in_tready;

    // Stage 1: capture accepted beat and the time it arrived
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else        vld_p1 <= hs;
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            tid_p1   <= axis_in_tid;
            seq_p1   <= axis_in_tdata[SEQ_LSB +: COUNT_WIDTH];
            tx_p1    <= axis_in_tdata[TS_LSB +: TS_W];
            acc_p1   <= ticks;
            tdest_p1 <= axis_in_tdest;
            tlast_p1 <= axis_in_tlast;
        end
    end

    // Stage 2: checks and statistics update
    always_comb begin
        tx_ext              = '0;
        acc_ext             = '0;
        tx_ext[TS_W-1:0]    = tx_p1;
        acc_ext[TS_W-1:0]   = acc_p1;
        lat_wide            = sat_sub(acc_ext, tx_ext, TS_W, LAT_WIDTH);
        lat_sample          = lat_wide[LAT_WIDTH-1:0];
    end

    assign fmt_ok  = (tdest_p1 == DEST) && tlast_p1;
    assign good    = vld_p1 && fmt_ok;
    assign seq_bad = (seq_p1 != exp_seq_q[tid_p1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_recv_q  <= '0;
            exp_seq_q     <= '0;
            recv_packets  <= '0;
            seq_err_count <= '0;
            fmt_err_count <= '0;
        end else if (clear) begin
            total_recv_q  <= '0;
            exp_seq_q     <= '0;
            recv_packets  <= '0;
            seq_err_count <= '0;
            fmt_err_count <= '0;
        end else begin
            if (hs) total_recv_q <= total_recv_q + 1'b1;
            if (vld_p1 && !fmt_ok) fmt_err_count <= fmt_err_count + 1'b1;
            if (good) begin
                // A mismatch is counted once, then tracking resyncs to the
                // received number so one lost packet is not a cascade.
                if (seq_bad) seq_err_count <= seq_err_count + 1'b1;
                recv_packets[tid_p1] <= recv_packets[tid_p1] + 1'b1;
                exp_seq_q[tid_p1]    <= seq_p1 + 1'b1;
            end
        end
    end

    axis_tc_lat_stats #(
        .LAT_WIDTH (LAT_WIDTH),
        .SUM_WIDTH (SUM_WIDTH)
    ) u_lat_stats (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .sample_vld (good),
        .sample     (lat_sample),
        .lat_sum    (lat_sum),
        .lat_min    (lat_min),
        .lat_max    (lat_max)
    );

    // Payload bits between sequence number and timestamp carry no meaning here.
    assign unused_bits = ^{axis_in_tdata[TS_LSB-1:SEQ_LSB+COUNT_WIDTH],
                           lat_wide[MAX_TS_W-1:LAT_WIDTH]};

endmodule

// File: tb/tb_axis_tc.sv
module tb_axis_tc;

    localparam int NSRC = 4;
    localparam int TS_W = 256;

    typedef struct packed {
        int                         due;
        logic [NSRC-1:0][31:0]      recv;
        logic [31:0]                seq_err;
        logic [31:0]                fmt_err;
        logic [63:0]                sum;
        logic [31:0]                lmin;
        logic [31:0]                lmax;
    } snap_t;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       start;
    logic [31:0]                num_packets;
    logic [TS_W-1:0]            ticks;
    logic                       done;
    logic [NSRC-1:0][31:0]      recv_packets;
    logic [31:0]                seq_err_count;
    logic [31:0]                fmt_err_count;
    logic [63:0]                lat_sum;
    logic [31:0]                lat_min;
    logic [31:0]                lat_max;
    logic                       axis_in_tvalid;
    logic                       axis_in_tready;
    logic [511:0]               axis_in_tdata;
    logic                       axis_in_tlast;
    logic [1:0]                 axis_in_tid;
    logic [1:0]                 axis_in_tdest;

    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    snap_t  m;
    snap_t  sb[$];
    logic [31:0] m_exp [NSRC];

    axis_tc dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .num_packets    (num_packets),
        .ticks          (ticks),
        .done           (done),
        .recv_packets   (recv_packets),
        .seq_err_count  (seq_err_count),
        .fmt_err_count  (fmt_err_count),
        .lat_sum        (lat_sum),
        .lat_min        (lat_min),
        .lat_max        (lat_max),
        .axis_in_tvalid (axis_in_tvalid),
        .axis_in_tready (axis_in_tready),
        .axis_in_tdata  (axis_in_tdata),
        .axis_in_tlast  (axis_in_tlast),
        .axis_in_tid    (axis_in_tid),
        .axis_in_tdest  (axis_in_tdest)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    task automatic model_clear();
        m.recv    = '0;
        m.seq_err = '0;
        m.fmt_err = '0;
        m.sum     = '0;
        m.lmin    = '1;
        m.lmax    = '0;
        for (int i = 0; i < NSRC; i++) m_exp[i] = '0;
    endtask

    task automatic model_accept(input logic [1:0] tid, input logic [31:0] seq,
                                input logic [TS_W-1:0] tx, input logic [1:0] tdest,
                                input logic tlast, input logic [TS_W-1:0] acc);
        logic [TS_W-1:0] diff;
        logic [31:0]     samp;
        logic [64:0]     s65;
        if (tdest != 2'd0 || !tlast) begin
            m.fmt_err = m.fmt_err + 1;
        end else begin
            if (seq != m_exp[tid]) m.seq_err = m.seq_err + 1;
            m.recv[tid] = m.recv[tid] + 1;
            m_exp[tid]  = seq + 1;
            diff = acc - tx;
            samp = (diff > 256'hFFFF_FFFF) ? 32'hFFFF_FFFF : diff[31:0];
            s65  = {1'b0, m.sum} + {33'b0, samp};
            m.sum = s65[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s65[63:0];
            if (samp < m.lmin) m.lmin = samp;
            if (samp > m.lmax) m.lmax = samp;
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        snap_t e;
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (recv_packets !== e.recv) begin
                    n_errors++;
                    $display("FAIL sb_recv: got %h expected %h", recv_packets, e.recv);
                end
                n_checks++;
                if (seq_err_count !== e.seq_err) begin
                    n_errors++;
                    $display("FAIL sb_seq_err: got %0d expected %0d", seq_err_count, e.seq_err);
                end
                n_checks++;
                if (fmt_err_count !== e.fmt_err) begin
                    n_errors++;
                    $display("FAIL sb_fmt_err: got %0d expected %0d", fmt_err_count, e.fmt_err);
                end
                n_checks++;
                if (lat_sum !== e.sum) begin
                    n_errors++;
                    $display("FAIL sb_lat_sum: got %h expected %h", lat_sum, e.sum);
                end
                n_checks++;
                if (lat_min !== e.lmin || lat_max !== e.lmax) begin
                    n_errors++;
                    $display("FAIL sb_lat_minmax: got %h/%h expected %h/%h",
                             lat_min, lat_max, e.lmin, e.lmax);
                end
            end
            if (axis_in_tvalid && axis_in_tready) begin
                model_accept(axis_in_tid, axis_in_tdata[31:0], axis_in_tdata[511:256],
                             axis_in_tdest, axis_in_tlast, ticks);
                m.due = cyc + 2;
                sb.push_back(m);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        ticks = ticks + 1;
    endtask

    task automatic send_beat(input logic [1:0] tid, input logic [31:0] seq,
                             input logic [TS_W-1:0] tx, input logic [1:0] tdest,
                             input logic tlast);
        logic hs;
        axis_in_tvalid = 1'b1;
        axis_in_tid    = tid;
        axis_in_tdest  = tdest;
        axis_in_tlast  = tlast;
        axis_in_tdata  = {tx, {7{32'hDEAD_BEEF}}, seq};
        hs = 1'b0;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            hs = axis_in_tready;
            step();
        end
        n_checks++;
        if (!hs) begin
            n_errors++;
            $display("FAIL send_timeout: tready got 0 expected 1 (tid %0d seq %0d)", tid, seq);
        end
    endtask

    task automatic start_run(input logic [31:0] np);
        num_packets = np;
        start       = 1'b1;
        model_clear();
        step();
        start       = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            seen = done;
            if (!seen) step();
        end
        step();
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL done_timeout: done got 0 expected 1 within %0d cycles", bound);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: pending %0d expected 0", sb.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n          = 1'b0;
        start          = 1'b0;
        num_packets    = '0;
        ticks          = 256'd1000;
        axis_in_tvalid = 1'b0;
        axis_in_tdata  = '0;
        axis_in_tlast  = 1'b0;
        axis_in_tid    = '0;
        axis_in_tdest  = '0;
        model_clear();
        repeat (3) step();
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || axis_in_tready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: done/tready got %b/%b expected 1/0", done, axis_in_tready);
        end
        n_checks++;
        if (recv_packets !== '0 || seq_err_count !== 32'd0 || fmt_err_count !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_counts: got %h %h %h expected zeros",
                     recv_packets, seq_err_count, fmt_err_count);
        end
        n_checks++;
        if (lat_sum !== 64'd0 || lat_min !== 32'hFFFF_FFFF || lat_max !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_lat: got %h/%h/%h expected 0/ffffffff/0", lat_sum, lat_min, lat_max);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_back_to_back();
        start_run(32'd4);
        for (int i = 0; i < 4; i++) send_beat(2'd1, i, ticks - 10, 2'd0, 1'b1);
        axis_in_tvalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (axis_in_tready !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_tready_drop: tready/done got %b/%b expected 0/0", axis_in_tready, done);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_done_early: done got %b expected 0", done);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_done_rise: done got %b expected 1", done);
        end
        step();
        n_checks++;
        if (recv_packets[1] !== 32'd4 || lat_min !== 32'd10 || lat_max !== 32'd10 || lat_sum !== 64'd40) begin
            n_errors++;
            $display("FAIL basic_stats: recv1/min/max/sum got %0d/%0d/%0d/%0d expected 4/10/10/40",
                     recv_packets[1], lat_min, lat_max, lat_sum);
        end
    endtask

    task automatic test_seq_err();
        logic [31:0] seqs [4];
        seqs = '{32'd0, 32'd1, 32'd3, 32'd4};
        start_run(32'd4);
        for (int i = 0; i < 4; i++) send_beat(2'd2, seqs[i], ticks - 10, 2'd0, 1'b1);
        axis_in_tvalid = 1'b0;
        wait_done(20);
        n_checks++;
        if (seq_err_count !== 32'd1 || recv_packets[2] !== 32'd4 || recv_packets[1] !== 32'd0) begin
            n_errors++;
            $display("FAIL seq_err: seq_err/recv2/recv1 got %0d/%0d/%0d expected 1/4/0",
                     seq_err_count, recv_packets[2], recv_packets[1]);
        end
    endtask

    task automatic test_fmt_err();
        start_run(32'd2);
        send_beat(2'd0, 32'd0, ticks - 10, 2'd1, 1'b1);
        send_beat(2'd0, 32'd0, ticks - 10, 2'd0, 1'b0);
        axis_in_tvalid = 1'b0;
        wait_done(20);
        n_checks++;
        if (fmt_err_count !== 32'd2 || recv_packets !== '0) begin
            n_errors++;
            $display("FAIL fmt_err: fmt/recv got %0d/%h expected 2/0", fmt_err_count, recv_packets);
        end
        n_checks++;
        if (lat_sum !== 64'd0 || lat_min !== 32'hFFFF_FFFF || lat_max !== 32'd0) begin
            n_errors++;
            $display("FAIL fmt_lat_untouched: got %h/%h/%h expected 0/ffffffff/0", lat_sum, lat_min, lat_max);
        end
    endtask

    task automatic test_ticks_wrap();
        logic [TS_W-1:0] tx;
        tx = '1;
        tx = tx - 2;
        start_run(32'd1);
        ticks = 256'd5;
        send_beat(2'd0, 32'd0, tx, 2'd0, 1'b1);
        axis_in_tvalid = 1'b0;
        wait_done(20);
        n_checks++;
        if (lat_min !== 32'd8 || lat_max !== 32'd8 || lat_sum !== 64'd8) begin
            n_errors++;
            $display("FAIL ticks_wrap: min/max/sum got %0d/%0d/%0d expected 8/8/8", lat_min, lat_max, lat_sum);
        end
    endtask

    task automatic test_lat_sat();
        start_run(32'd1);
        ticks = 256'd1 << 40;
        send_beat(2'd1, 32'd0, '0, 2'd0, 1'b1);
        axis_in_tvalid = 1'b0;
        wait_done(20);
        n_checks++;
        if (lat_min !== 32'hFFFF_FFFF || lat_max !== 32'hFFFF_FFFF || lat_sum !== 64'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL lat_sat: min/max/sum got %h/%h/%h expected ffffffff/ffffffff/ffffffff",
                     lat_min, lat_max, lat_sum);
        end
        ticks = 256'd5000;
    endtask

    task automatic test_reset_mid_run();
        logic [NSRC-1:0][31:0] exp_recv;
        start_run(32'd8);
        for (int i = 0; i < 3; i++) send_beat(2'd0, i, ticks - 10, 2'd0, 1'b1);
        axis_in_tvalid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        model_clear();
        #2;
        n_checks++;
        if ({done, axis_in_tready, recv_packets, seq_err_count, fmt_err_count, lat_sum, lat_min, lat_max}
            !== {1'b1, 1'b0, 128'd0, 32'd0, 32'd0, 64'd0, 32'hFFFF_FFFF, 32'd0}) begin
            n_errors++;
            $display("FAIL mid_reset_vals: done %b tready %b recv %h seq %0d fmt %0d sum %h min %h max %h expected reset values",
                     done, axis_in_tready, recv_packets, seq_err_count, fmt_err_count, lat_sum, lat_min, lat_max);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        start_run(32'd2);
        send_beat(2'd3, 32'd0, ticks - 10, 2'd0, 1'b1);
        send_beat(2'd3, 32'd1, ticks - 10, 2'd0, 1'b1);
        axis_in_tvalid = 1'b0;
        wait_done(20);
        exp_recv    = '0;
        exp_recv[3] = 32'd2;
        n_checks++;
        if (recv_packets !== exp_recv || seq_err_count !== 32'd0 || lat_sum !== 64'd20) begin
            n_errors++;
            $display("FAIL mid_reset_restart: recv/seq/sum got %h/%0d/%0d expected %h/0/20",
                     recv_packets, seq_err_count, lat_sum, exp_recv);
        end
    endtask

    task automatic test_zero_packets();
        logic seen_done;
        logic seen_ready;
        seen_done  = 1'b0;
        seen_ready = 1'b0;
        axis_in_tvalid = 1'b1;
        axis_in_tid    = 2'd0;
        axis_in_tdest  = 2'd0;
        axis_in_tlast  = 1'b1;
        axis_in_tdata  = {ticks, {7{32'hDEAD_BEEF}}, 32'd0};
        start_run(32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (axis_in_tready) seen_ready = 1'b1;
            if (done) seen_done = 1'b1;
            step();
        end
        axis_in_tvalid = 1'b0;
        n_checks++;
        if (seen_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_tready: tready seen %b expected 0", seen_ready);
        end
        n_checks++;
        if (seen_done !== 1'b1) begin
            n_errors++;
            $display("FAIL zero_done: done seen %b expected 1 within 3 cycles", seen_done);
        end
    endtask

    task automatic test_start_ignored();
        start_run(32'd6);
        send_beat(2'd0, 32'd0, ticks - 10, 2'd0, 1'b1);
        send_beat(2'd0, 32'd1, ticks - 10, 2'd0, 1'b1);
        start = 1'b1;
        send_beat(2'd0, 32'd2, ticks - 10, 2'd0, 1'b1);
        start = 1'b0;
        for (int i = 3; i < 6; i++) send_beat(2'd0, i, ticks - 10, 2'd0, 1'b1);
        axis_in_tvalid = 1'b0;
        wait_done(20);
        n_checks++;
        if (recv_packets[0] !== 32'd6 || seq_err_count !== 32'd0 || lat_sum !== 64'd60) begin
            n_errors++;
            $display("FAIL start_ignored: recv0/seq/sum got %0d/%0d/%0d expected 6/0/60",
                     recv_packets[0], seq_err_count, lat_sum);
        end
    endtask

    initial begin
        test_reset();
        test_basic_back_to_back();
        test_seq_err();
        test_fmt_err();
        test_ticks_wrap();
        test_lat_sat();
        test_reset_mid_run();
        test_zero_packets();
        test_start_ignored();
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
